// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: shared types for the multi-cycle RV32I control path
//   package rv32i_pkg: opcodes, ALU op encoding, FSM states, instruction
//   classes and datapath mux select encodings.
package rv32i_pkg;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100
   } alu_op_t;
   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
   typedef enum logic [2:0] {CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL, CL_BAD} iclass_t;
   typedef enum logic {SRC_A_RS1, SRC_A_PC} src_a_t;
   typedef enum logic [1:0] {SRC_B_RS2, SRC_B_IMM, SRC_B_FOUR} src_b_t;
   typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_LINK} wb_sel_t;
   typedef enum logic {PC_ALU, PC_ALUOUT} pc_src_t;
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control <-> datapath/memory signal bundle
//   master: control FSM (consumes instr/zero/mem_ready, drives strobes)
//   slave : datapath side (drives instr/zero/mem_ready, consumes strobes)
interface multicycle_control_if;
   logic [31:0] instr;
   logic        zero;
   logic        mem_ready;
   logic        mem_req;
   logic        mem_we;
   logic        mem_addr_sel;
   logic        ir_write;
   logic        pc_write;
   logic        pc_src;
   logic        alu_out_we;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic [2:0]  alu_op;
   logic        reg_write;
   logic [1:0]  wb_sel;
   logic        retire;
   logic        illegal;
   modport master (
      input  instr, zero, mem_ready,
      output mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, alu_out_we,
             alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, retire, illegal
   );
   modport slave (
      output instr, zero, mem_ready,
      input  mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, alu_out_we,
             alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, retire, illegal
   );
endinterface

// File: rtl/multicycle_control_classify.sv
// instr_classify: combinational decode of instr into class, ALU op and legality
//   in : instr[31:0]
//   out: iclass, alu_op, legal
module instr_classify
   import rv32i_pkg::*;
(
   input  logic [31:0] instr,
   output iclass_t     iclass,
   output alu_op_t     alu_op,
   output logic        legal
);
   logic [6:0] opc;
   logic [6:0] f7;
   logic [2:0] f3;
   logic       f3_ok;
   logic       unused_bits;
   alu_op_t    f3_op;
   assign opc = instr[6:0];
   assign f3 = instr[14:12];
   assign f7 = instr[31:25];
   assign unused_bits = ^{instr[24:15], instr[11:7]};
   assign f3_ok = f3 == 3'b000 || f3 == 3'b100 || f3 == 3'b110 || f3 == 3'b111;
   assign f3_op = f3 == 3'b100 ? ALU_XOR : f3 == 3'b110 ? ALU_OR : f3 == 3'b111 ? ALU_AND : ALU_ADD;
   always_comb begin
      iclass = CL_BAD;
      alu_op = ALU_ADD;
      legal = 1'b0;
      case (opc)
         OP_R: begin
            iclass = CL_R;
            alu_op = f7[5] ? ALU_SUB : f3_op;
            // the alternate funct7 only exists for SUB
            legal = f3_ok && (f7 == 7'b0000000 || (f7 == 7'b0100000 && f3 == 3'b000));
         end
         OP_I: begin
            iclass = CL_I;
            alu_op = f3_op;
            legal = f3_ok;
         end
         OP_LOAD: begin
            iclass = CL_LOAD;
            legal = f3 == 3'b010;
         end
         OP_STORE: begin
            iclass = CL_STORE;
            legal = f3 == 3'b010;
         end
         OP_BRANCH: begin
            iclass = CL_BRANCH;
            alu_op = ALU_SUB;
            legal = f3[2:1] == 2'b00;
         end
         OP_JAL: begin
            iclass = CL_JAL;
            legal = 1'b1;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main sequencing FSM of the multi-cycle RV32I core
//   clk, rst (sync, active high)
//   bus (master): instr/zero/mem_ready in; memory, ALU, PC, IR and
//   register-file strobes out; retire pulse and sticky illegal flag.
module multicycle_control
   import rv32i_pkg::*;
#(
   parameter int ADDR_ALIGN_CHECK = 1
) (
   input logic                 clk,
   input logic                 rst,
   multicycle_control_if.master bus
);
   state_t  state, state_n;
   iclass_t iclass;
   alu_op_t dec_op, op;
   src_a_t  sa;
   src_b_t  sb;
   wb_sel_t wbs;
   pc_src_t pcs;
   logic    legal, illegal_q, taken, misalign;
   logic    req, we, addr_sel, irw, pcw, aluw, rw, ret;
   instr_classify u_classify (.instr(bus.instr), .iclass(iclass), .alu_op(dec_op), .legal(legal));
   assign taken = bus.zero ^ bus.instr[12];
   // old_pc is word aligned, so target bit 1 is immediate bit 1 (JAL: instr[21], B-type: instr[8])
   assign misalign = ADDR_ALIGN_CHECK != 0 && (iclass == CL_JAL ? bus.instr[21] : bus.instr[8]);
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FETCH;
         illegal_q <= 1'b0;
      end else begin
         state <= state_n;
         illegal_q <= illegal_q | (state_n == TRAP);
      end
   end
   always_comb begin
      state_n = state;
      req = 1'b0;
      we = 1'b0;
      addr_sel = 1'b0;
      irw = 1'b0;
      pcw = 1'b0;
      pcs = PC_ALU;
      aluw = 1'b0;
      sa = SRC_A_RS1;
      sb = SRC_B_RS2;
      op = ALU_ADD;
      rw = 1'b0;
      wbs = WB_ALU;
      ret = 1'b0;
      case (state)
         FETCH: begin
            req = 1'b1;
            sa = SRC_A_PC;
            sb = SRC_B_FOUR;
            if (bus.mem_ready) begin
               irw = 1'b1;
               pcw = 1'b1;
               state_n = DECODE;
            end
         end
         DECODE: begin
            // speculative branch/jump target into ALUOut
            sa = SRC_A_PC;
            sb = SRC_B_IMM;
            aluw = 1'b1;
            state_n = legal ? EXEC : TRAP;
         end
         EXEC: begin
            case (iclass)
               CL_R: begin
                  aluw = 1'b1;
                  op = dec_op;
                  state_n = WB;
               end
               CL_I: begin
                  sb = SRC_B_IMM;
                  aluw = 1'b1;
                  op = dec_op;
                  state_n = WB;
               end
               CL_LOAD, CL_STORE: begin
                  sb = SRC_B_IMM;
                  aluw = 1'b1;
                  state_n = MEM;
               end
               CL_BRANCH: begin
                  op = ALU_SUB;
                  if (taken && misalign) state_n = TRAP;
                  else begin
                     pcw = taken;
                     pcs = taken ? PC_ALUOUT : PC_ALU;
                     ret = 1'b1;
                     state_n = FETCH;
                  end
               end
               CL_JAL: begin
                  if (misalign) state_n = TRAP;
                  else begin
                     pcw = 1'b1;
                     pcs = PC_ALUOUT;
                     rw = 1'b1;
                     wbs = WB_LINK;
                     ret = 1'b1;
                     state_n = FETCH;
                  end
               end
               default: state_n = TRAP;
            endcase
         end
         MEM: begin
            req = 1'b1;
            addr_sel = 1'b1;
            we = iclass == CL_STORE;
            if (bus.mem_ready) begin
               ret = iclass == CL_STORE;
               state_n = iclass == CL_STORE ? FETCH : WB;
            end
         end
         WB: begin
            rw = 1'b1;
            wbs = iclass == CL_LOAD ? WB_MEM : WB_ALU;
            ret = 1'b1;
            state_n = FETCH;
         end
         TRAP: ;
         default: state_n = FETCH;
      endcase
   end
   assign bus.mem_req = req & ~rst;
   assign bus.mem_we = we & ~rst;
   assign bus.mem_addr_sel = addr_sel & ~rst;
   assign bus.ir_write = irw & ~rst;
   assign bus.pc_write = pcw & ~rst;
   assign bus.pc_src = rst ? 1'b0 : pcs;
   assign bus.alu_out_we = aluw & ~rst;
   assign bus.alu_src_a = rst ? 1'b0 : sa;
   assign bus.alu_src_b = rst ? 2'd0 : sb;
   assign bus.alu_op = rst ? 3'd0 : op;
   assign bus.reg_write = rw & ~rst;
   assign bus.wb_sel = rst ? 2'd0 : wbs;
   assign bus.retire = ret & ~rst;
   assign bus.illegal = illegal_q & ~rst;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table-driven per-cycle check of the control FSM outputs
module tb_multicycle_control;
   typedef struct packed {
      logic       mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, alu_out_we, alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic       reg_write;
      logic [1:0] wb_sel;
      logic       retire, illegal;
   } out_t;
   typedef struct {
      logic        rst, rdy, zero;
      logic [31:0] instr;
      out_t        exp;
      string       name;
   } vec_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   multicycle_control_if bus();
   multicycle_control #(.ADDR_ALIGN_CHECK(1)) dut (.clk(clk), .rst(rst), .bus(bus));
   out_t act;
   assign act = {bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.ir_write, bus.pc_write, bus.pc_src,
                 bus.alu_out_we, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.reg_write, bus.wb_sel,
                 bus.retire, bus.illegal};
   vec_t tbl[$];
   int nvec = 0;
   int nbad = 0;
   out_t RST, F_W, F_D, DEC, M_LD, M_SW, M_SWD, WB_A, WB_L, BR_T, BR_N, BR_X, JAL_E, JAL_X, TRP;
   function automatic out_t mk(input logic req, we, asel, irw, pcw, pcs, aluw, sa,
                               input logic [1:0] sb, input logic [2:0] op,
                               input logic rw, input logic [1:0] wbs, input logic ret, il);
      return {req, we, asel, irw, pcw, pcs, aluw, sa, sb, op, rw, wbs, ret, il};
   endfunction
   function automatic out_t exr(input logic [2:0] op);
      return mk(0,0,0,0,0,0,1,0,2'd0,op,0,2'd0,0,0);
   endfunction
   function automatic out_t exi(input logic [2:0] op);
      return mk(0,0,0,0,0,0,1,0,2'd1,op,0,2'd0,0,0);
   endfunction
   function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3);
      return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
   endfunction
   function automatic logic [31:0] itype(input logic [11:0] imm, input logic [2:0] f3);
      return {imm, 5'd1, f3, 5'd3, 7'b0010011};
   endfunction
   task automatic add(input logic r, rdy, z, input logic [31:0] ins, input out_t e, input string nm);
      vec_t v;
      v.rst = r;
      v.rdy = rdy;
      v.zero = z;
      v.instr = ins;
      v.exp = e;
      v.name = nm;
      tbl.push_back(v);
   endtask
   task automatic s3(input logic [31:0] ins, input logic z, input out_t ex, input string nm);
      add(0, 1, z, ins, F_D, {nm, ".fetch"});
      add(0, 1, z, ins, DEC, {nm, ".decode"});
      add(0, 1, z, ins, ex, {nm, ".exec"});
   endtask
   task automatic trap_seq(input logic [31:0] ins, input string nm);
      add(0, 1, 0, ins, F_D, {nm, ".fetch"});
      add(0, 1, 0, ins, DEC, {nm, ".decode"});
      add(0, 1, 0, ins, TRP, {nm, ".trap"});
      add(1, 1, 0, ins, RST, {nm, ".rst"});
   endtask
   task automatic apply(input logic r, rdy, z, input logic [31:0] ins, input out_t e, input string nm);
      @(negedge clk);
      rst = r;
      bus.mem_ready = rdy;
      bus.zero = z;
      bus.instr = ins;
      #1;
      nvec++;
      if (act !== e) begin
         nbad++;
         $display("FAIL %s: got %h expected %h", nm, act, e);
      end
   endtask
   initial begin
      logic [31:0] lw, sw, beq, bne, beq_mis, jal, jal_mis, lui;
      bus.mem_ready = 1'b0;
      bus.zero = 1'b0;
      bus.instr = '0;
      RST   = mk(0,0,0,0,0,0,0,0,2'd0,3'd0,0,2'd0,0,0);
      F_W   = mk(1,0,0,0,0,0,0,1,2'd2,3'd0,0,2'd0,0,0);
      F_D   = mk(1,0,0,1,1,0,0,1,2'd2,3'd0,0,2'd0,0,0);
      DEC   = mk(0,0,0,0,0,0,1,1,2'd1,3'd0,0,2'd0,0,0);
      M_LD  = mk(1,0,1,0,0,0,0,0,2'd0,3'd0,0,2'd0,0,0);
      M_SW  = mk(1,1,1,0,0,0,0,0,2'd0,3'd0,0,2'd0,0,0);
      M_SWD = mk(1,1,1,0,0,0,0,0,2'd0,3'd0,0,2'd0,1,0);
      WB_A  = mk(0,0,0,0,0,0,0,0,2'd0,3'd0,1,2'd0,1,0);
      WB_L  = mk(0,0,0,0,0,0,0,0,2'd0,3'd0,1,2'd1,1,0);
      BR_T  = mk(0,0,0,0,1,1,0,0,2'd0,3'd1,0,2'd0,1,0);
      BR_N  = mk(0,0,0,0,0,0,0,0,2'd0,3'd1,0,2'd0,1,0);
      BR_X  = mk(0,0,0,0,0,0,0,0,2'd0,3'd1,0,2'd0,0,0);
      JAL_E = mk(0,0,0,0,1,1,0,0,2'd0,3'd0,1,2'd2,1,0);
      JAL_X = mk(0,0,0,0,0,0,0,0,2'd0,3'd0,0,2'd0,0,0);
      TRP   = mk(0,0,0,0,0,0,0,0,2'd0,3'd0,0,2'd0,0,1);
      lw      = {12'd8, 5'd1, 3'b010, 5'd3, 7'b0000011};
      sw      = {7'd0, 5'd2, 5'd1, 3'b010, 5'd8, 7'b0100011};
      beq     = {7'd0, 5'd2, 5'd1, 3'b000, 5'b01000, 7'b1100011};
      bne     = {7'd0, 5'd2, 5'd1, 3'b001, 5'b01000, 7'b1100011};
      beq_mis = {7'd0, 5'd2, 5'd1, 3'b000, 5'b00010, 7'b1100011};
      jal     = {20'h00800, 5'd1, 7'b1101111};
      jal_mis = {20'h00200, 5'd1, 7'b1101111};
      lui     = {20'h12345, 5'd3, 7'b0110111};
      add(1, 1, 0, 32'd0, RST, "reset");
      s3(rtype(7'h00, 3'b000), 0, exr(3'd0), "add");
      add(0, 1, 0, rtype(7'h00, 3'b000), WB_A, "add.wb");
      s3(rtype(7'h20, 3'b000), 0, exr(3'd1), "sub");
      add(0, 1, 0, rtype(7'h20, 3'b000), WB_A, "sub.wb");
      s3(rtype(7'h00, 3'b100), 0, exr(3'd4), "xor");
      add(0, 1, 0, rtype(7'h00, 3'b100), WB_A, "xor.wb");
      s3(rtype(7'h00, 3'b110), 0, exr(3'd3), "or");
      add(0, 1, 0, rtype(7'h00, 3'b110), WB_A, "or.wb");
      s3(rtype(7'h00, 3'b111), 0, exr(3'd2), "and");
      add(0, 1, 0, rtype(7'h00, 3'b111), WB_A, "and.wb");
      s3(itype(12'h400, 3'b000), 0, exi(3'd0), "addi_f7set");
      add(0, 1, 0, itype(12'h400, 3'b000), WB_A, "addi_f7set.wb");
      s3(itype(12'd5, 3'b100), 0, exi(3'd4), "xori");
      add(0, 1, 0, itype(12'd5, 3'b100), WB_A, "xori.wb");
      for (int i = 0; i < 3; i++) add(0, 0, 0, lw, F_W, "lw.fetch_wait");
      s3(lw, 0, exi(3'd0), "lw");
      for (int i = 0; i < 3; i++) add(0, 0, 0, lw, M_LD, "lw.mem_wait");
      add(0, 1, 0, lw, M_LD, "lw.mem_done");
      add(0, 1, 0, lw, WB_L, "lw.wb");
      s3(sw, 0, exi(3'd0), "sw");
      add(0, 1, 0, sw, M_SWD, "sw.mem_done");
      s3(beq, 1, BR_T, "beq_z1");
      s3(bne, 1, BR_N, "bne_z1");
      s3(beq, 0, BR_N, "beq_z0");
      s3(bne, 0, BR_T, "bne_z0");
      s3(jal, 0, JAL_E, "jal");
      s3(beq_mis, 1, BR_X, "beq_mis");
      add(0, 1, 1, beq_mis, TRP, "beq_mis.trap");
      add(1, 1, 0, beq_mis, RST, "beq_mis.rst");
      s3(beq_mis, 0, BR_N, "beq_mis_nt");
      s3(jal_mis, 0, JAL_X, "jal_mis");
      add(0, 1, 0, jal_mis, TRP, "jal_mis.trap");
      add(1, 1, 0, jal_mis, RST, "jal_mis.rst");
      trap_seq(itype(12'd1, 3'b001), "slli");
      trap_seq(rtype(7'h20, 3'b100), "sub_f3bad");
      trap_seq(rtype(7'h01, 3'b000), "mul");
      trap_seq({12'd8, 5'd1, 3'b000, 5'd3, 7'b0000011}, "lb");
      foreach (tbl[i]) apply(tbl[i].rst, tbl[i].rdy, tbl[i].zero, tbl[i].instr, tbl[i].exp, tbl[i].name);
      apply(0, 1, 0, lui, F_D, "lui.fetch");
      apply(0, 1, 0, lui, DEC, "lui.decode");
      for (int i = 0; i < 20; i++) apply(0, 1, i[0], lui, TRP, "lui.trap_hold");
      apply(1, 1, 0, lui, RST, "lui.rst");
      apply(0, 0, 0, lui, F_W, "lui.refetch");
      apply(0, 1, 0, sw, F_D, "sw_rst.fetch");
      apply(0, 1, 0, sw, DEC, "sw_rst.decode");
      apply(0, 1, 0, sw, exi(3'd0), "sw_rst.exec");
      apply(0, 0, 0, sw, M_SW, "sw_rst.mem_wait");
      apply(0, 0, 0, sw, M_SW, "sw_rst.mem_wait");
      apply(1, 1, 0, sw, RST, "sw_rst.in_reset");
      apply(0, 0, 0, sw, F_W, "sw_rst.refetch");
      apply(0, 1, 0, sw, F_D, "sw_rst.refetch_done");
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end
endmodule
